// File: rtl/mcp9808_pkg.sv
// Shared definitions for the MCP9808-style I2C temperature sensor target and its bus master.
package mcp9808_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned PTR_W   = 4;
  localparam int unsigned TEMP_W  = 13;
  localparam int unsigned BOUND_W = 11;
  localparam int unsigned CFG_W   = 9;
  localparam int unsigned RES_W   = 2;

  localparam logic [3:0] ADDR_PREFIX = 4'b0011;

  localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] ST_ADDR     = 4'd1;
  localparam logic [STATE_W-1:0] ST_ADDR_ACK = 4'd2;
  localparam logic [STATE_W-1:0] ST_PTR      = 4'd3;
  localparam logic [STATE_W-1:0] ST_PTR_ACK  = 4'd4;
  localparam logic [STATE_W-1:0] ST_WR_DATA  = 4'd5;
  localparam logic [STATE_W-1:0] ST_WR_ACK   = 4'd6;
  localparam logic [STATE_W-1:0] ST_RD_DATA  = 4'd7;
  localparam logic [STATE_W-1:0] ST_RD_ACK   = 4'd8;
  localparam logic [STATE_W-1:0] ST_IGNORE   = 4'd9;

  localparam logic [PTR_W-1:0] PTR_CONFIG  = 4'd1;
  localparam logic [PTR_W-1:0] PTR_T_UPPER = 4'd2;
  localparam logic [PTR_W-1:0] PTR_T_LOWER = 4'd3;
  localparam logic [PTR_W-1:0] PTR_T_CRIT  = 4'd4;
  localparam logic [PTR_W-1:0] PTR_TEMP    = 4'd5;
  localparam logic [PTR_W-1:0] PTR_MAN_ID  = 4'd6;
  localparam logic [PTR_W-1:0] PTR_DEV_ID  = 4'd7;
  localparam logic [PTR_W-1:0] PTR_RES     = 4'd8;

  // Ambient register: alarm flags over the raw reading; bounds carry two implied zero LSBs.
  function automatic logic [15:0] temp_word(input logic [TEMP_W-1:0]  ta,
                                            input logic [BOUND_W-1:0] up,
                                            input logic [BOUND_W-1:0] lo,
                                            input logic [BOUND_W-1:0] crit);
    logic signed [TEMP_W-1:0] t, u, l, c;
    t = signed'(ta);
    u = signed'({up, 2'b00});
    l = signed'({lo, 2'b00});
    c = signed'({crit, 2'b00});
    return {t >= c, t > u, t < l, ta};
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and emits registered START, STOP and SCL edge pulses.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       start_q, stop_q, rise_q, fall_q, sda_q;
  logic       start_d, stop_d, rise_d, fall_d, sda_d;

  always_comb begin
    start_d = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
    stop_d  = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
    rise_d  = scl_sync_q[1] & ~scl_prev_q;
    fall_d  = ~scl_sync_q[1] & scl_prev_q;
    sda_d   = sda_sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      start_q    <= start_d;
      stop_q     <= stop_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      sda_q      <= sda_d;
    end
  end

  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/mcp9808_target.sv
// I2C target exposing MCP9808-style config, bound, temperature, ID and resolution registers.
module mcp9808_target
  import mcp9808_pkg::*;
#(
  parameter logic [2:0]  SLAVE_ADD = 3'b000,
  parameter logic [15:0] MAN_ID    = 16'h0054,
  parameter logic [15:0] DEV_ID    = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [12:0] temp_i,
  output logic [8:0]  config_o,
  output logic [10:0] t_upper_o,
  output logic [10:0] t_lower_o,
  output logic [10:0] t_crit_o,
  output logic [1:0]  res_o,
  output logic        busy
);

  logic start, stop, scl_rise, scl_fall, sda_in;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst_n     (rst),
    .scl_i     (SCL),
    .sda_i     (SDA),
    .start_o   (start),
    .stop_o    (stop),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .sda_o     (sda_in)
  );

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         rx_q, rx_d;
  logic [6:0]         tx_q, tx_d;
  logic [7:0]         lsb_q, lsb_d;
  logic [4:0]         msb_q, msb_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
  logic               idx_q, idx_d, done_q, done_d, nack_q, nack_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [BOUND_W-1:0] up_q, up_d, lo_q, lo_d, crit_q, crit_d;
  logic [RES_W-1:0]   res_q, res_d;

  logic [15:0] rd_word;
  logic [12:0] wr_word;
  logic        rd_first;
  logic [7:0]  ld_byte;

  // Register read mux; the whole word is captured when a MSB byte is loaded.
  always_comb begin
    rd_word = 16'h0000;
    case (ptr_q)
      PTR_CONFIG:  rd_word = {7'b0, cfg_q};
      PTR_T_UPPER: rd_word = {3'b0, up_q, 2'b00};
      PTR_T_LOWER: rd_word = {3'b0, lo_q, 2'b00};
      PTR_T_CRIT:  rd_word = {3'b0, crit_q, 2'b00};
      PTR_TEMP:    rd_word = temp_word(temp_i, up_q, lo_q, crit_q);
      PTR_MAN_ID:  rd_word = MAN_ID;
      PTR_DEV_ID:  rd_word = DEV_ID;
      PTR_RES:     rd_word = {6'b0, res_q, 6'b0, res_q};
      default:     rd_word = 16'h0000;
    endcase
  end

  assign wr_word  = {msb_q, rx_q};
  assign rd_first = (state_q == ST_ADDR_ACK) || !idx_q;
  assign ld_byte  = rd_first ? rd_word[15:8] : lsb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    lsb_d   = lsb_q;
    msb_d   = msb_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    done_d  = done_q;
    nack_d  = nack_q;
    cfg_d   = cfg_q;
    up_d    = up_q;
    lo_d    = lo_q;
    crit_d  = crit_q;
    res_d   = res_q;

    if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if (start) begin
      state_d = ST_ADDR;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            rx_d  = {rx_q[6:0], sda_in};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (rx_q[7:1] == {ADDR_PREFIX, SLAVE_ADD}) begin
                state_d = ST_ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                rw_d    = rx_q[0];
              end else begin
                state_d = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = rx_q[3:0];
              state_d = ST_PTR_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = ST_WR_ACK;
              oe_d    = 1'b1;
              // Resolution commits on its only byte; 16-bit registers on the LSB byte.
              if (!done_q) begin
                if (ptr_q == PTR_RES) begin
                  res_d  = rx_q[1:0];
                  done_d = 1'b1;
                end else if (!idx_q) begin
                  msb_d = rx_q[4:0];
                  idx_d = 1'b1;
                end else begin
                  done_d = 1'b1;
                  case (ptr_q)
                    PTR_CONFIG:  cfg_d  = wr_word[8:0];
                    PTR_T_UPPER: up_d   = wr_word[12:2];
                    PTR_T_LOWER: lo_d   = wr_word[12:2];
                    PTR_T_CRIT:  crit_d = wr_word[12:2];
                    default:     ;
                  endcase
                end
              end
            end
          end
        end
        ST_ADDR_ACK, ST_RD_ACK: begin
          if (state_q == ST_RD_ACK && scl_rise) begin
            nack_d = sda_in;
          end else if (scl_fall) begin
            if (state_q == ST_ADDR_ACK && !rw_q) begin
              state_d = ST_PTR;
              oe_d    = 1'b0;
            end else if (state_q == ST_RD_ACK && nack_q) begin
              state_d = ST_IGNORE;
              oe_d    = 1'b0;
            end else begin
              state_d = ST_RD_DATA;
              oe_d    = ~ld_byte[7];
              tx_d    = ld_byte[6:0];
              idx_d   = rd_first;
              if (rd_first) begin
                lsb_d = rd_word[7:0];
              end
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            state_d = ST_WR_DATA;
            oe_d    = 1'b0;
            if (state_q == ST_PTR_ACK) begin
              idx_d  = 1'b0;
              done_d = 1'b0;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = ST_RD_ACK;
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rx_q    <= 8'h00;
      tx_q    <= 7'h00;
      lsb_q   <= 8'h00;
      msb_q   <= 5'h00;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      idx_q   <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      cfg_q   <= '0;
      up_q    <= '0;
      lo_q    <= '0;
      crit_q  <= '0;
      res_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      lsb_q   <= lsb_d;
      msb_q   <= msb_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      cfg_q   <= cfg_d;
      up_q    <= up_d;
      lo_q    <= lo_d;
      crit_q  <= crit_d;
      res_q   <= res_d;
    end
  end

  assign SDA       = oe_q ? 1'b0 : 1'bz;
  assign config_o  = cfg_q;
  assign t_upper_o = up_q;
  assign t_lower_o = lo_q;
  assign t_crit_o  = crit_q;
  assign res_o     = res_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mcp9808_target.sv
// Directed I2C master bench for mcp9808_target with a scoreboard of expected ACKs, bytes and registers.
module tb_mcp9808_target;

  localparam int Q = 10;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_low;
  logic [12:0] temp_i;
  logic [8:0]  config_o;
  logic [10:0] t_upper_o, t_lower_o, t_crit_o;
  logic [1:0]  res_o;
  logic        busy;
  wire         sda_bus;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  mcp9808_target dut (
    .clk      (clk),
    .rst      (rst),
    .SCL      (scl),
    .SDA      (sda_bus),
    .temp_i   (temp_i),
    .config_o (config_o),
    .t_upper_o(t_upper_o),
    .t_lower_o(t_lower_o),
    .t_crit_o (t_crit_o),
    .res_o    (res_o),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic [8:0]  m_cfg;
  logic [10:0] m_up, m_lo, m_crit;
  logic [1:0]  m_res;
  logic [15:0] w;
  logic        s;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push(e);
    check(tag, obs);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL pulse: drive b (1 = release), sample the line mid-high.
  task automatic clk_bit(input logic b, output logic smp);
    sda_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    smp = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(H);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(H);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_low = 1'b0;
    wait_clk(Q);
  endtask

  task automatic wr(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a, d;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
    push(32'(exp_ack));
    clk_bit(1'b1, a);
    check(tag, 32'(a));
  endtask

  task automatic rd(input logic [7:0] e, input logic nack, input string tag);
    logic [7:0] v;
    logic d;
    push(32'(e));
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, d);
      v[i] = d;
    end
    clk_bit(nack, d);
    sda_low = 1'b0;
    check(tag, 32'(v));
  endtask

  function automatic logic [15:0] temp_model(input logic [12:0] ta, input logic [10:0] up,
                                             input logic [10:0] lo, input logic [10:0] cr);
    int t, u, l, c;
    t = ta[12] ? int'(ta) - 8192 : int'(ta);
    u = up[10] ? (int'(up) - 2048) * 4 : int'(up) * 4;
    l = lo[10] ? (int'(lo) - 2048) * 4 : int'(lo) * 4;
    c = cr[10] ? (int'(cr) - 2048) * 4 : int'(cr) * 4;
    return {(t >= c), (t > u), (t < l), ta};
  endfunction

  task automatic model_reset();
    m_cfg = '0; m_up = '0; m_lo = '0; m_crit = '0; m_res = 2'b11;
  endtask

  initial begin
    rst = 1'b0; scl = 1'b1; sda_low = 1'b0; temp_i = 13'h0000;
    model_reset();
    wait_clk(4);
    expect_val("rst_config", 32'(config_o), 32'(m_cfg));
    expect_val("rst_bounds", {t_upper_o, t_lower_o, t_crit_o}, 32'h0);
    expect_val("rst_res", 32'(res_o), 32'(m_res));
    expect_val("rst_busy", 32'(busy), 32'h0);
    expect_val("rst_sda", 32'(sda_bus), 32'h1);
    rst = 1'b1;
    wait_clk(4);

    // T_UPPER = 25.0 degC
    i2c_start();
    wr(8'h30, 1'b0, "up_addr_ack");
    expect_val("busy_matched", 32'(busy), 32'h1);
    wr(8'h02, 1'b0, "up_ptr_ack");
    wr(8'h01, 1'b0, "up_msb_ack");
    expect_val("up_not_yet", 32'(t_upper_o), 32'(m_up));
    wr(8'h90, 1'b0, "up_lsb_ack");
    m_up = 11'h064;
    expect_val("t_upper", 32'(t_upper_o), 32'(m_up));
    i2c_stop();
    expect_val("busy_after_stop", 32'(busy), 32'h0);

    // T_CRIT = 80 degC so only the upper alarm trips at 26 degC
    i2c_start();
    wr(8'h30, 1'b0, "crit_addr_ack");
    wr(8'h04, 1'b0, "crit_ptr_ack");
    wr(8'h05, 1'b0, "crit_msb_ack");
    wr(8'h00, 1'b0, "crit_lsb_ack");
    m_crit = 11'h140;
    expect_val("t_crit", 32'(t_crit_o), 32'(m_crit));
    i2c_stop();

    // Temperature read with repeated START; temp changes between bytes
    temp_i = 13'h01A0;
    w = temp_model(temp_i, m_up, m_lo, m_crit);
    i2c_start();
    wr(8'h30, 1'b0, "ta_addr_ack");
    wr(8'h05, 1'b0, "ta_ptr_ack");
    i2c_start();
    wr(8'h31, 1'b0, "ta_raddr_ack");
    rd(w[15:8], 1'b0, "ta_msb");
    temp_i = 13'h1FF0;
    rd(w[7:0], 1'b1, "ta_lsb_snap");
    wait_clk(Q);
    expect_val("ta_sda_released", 32'(sda_bus), 32'h1);
    i2c_stop();

    // Foreign address
    i2c_start();
    wr(8'h32, 1'b1, "foreign_nack");
    expect_val("foreign_busy", 32'(busy), 32'h0);
    wr(8'h02, 1'b1, "foreign_data_nack");
    expect_val("foreign_busy2", 32'(busy), 32'h0);
    expect_val("foreign_regs", {t_upper_o, t_crit_o}, {m_up, m_crit});
    i2c_stop();

    // Manufacturer ID, three bytes
    i2c_start();
    wr(8'h30, 1'b0, "mid_addr_ack");
    wr(8'h06, 1'b0, "mid_ptr_ack");
    i2c_start();
    wr(8'h31, 1'b0, "mid_raddr_ack");
    rd(8'h00, 1'b0, "mid_b0");
    rd(8'h54, 1'b0, "mid_b1");
    rd(8'h00, 1'b1, "mid_b2");
    i2c_stop();

    // Partial CONFIG write, then writes to a read-only register
    i2c_start();
    wr(8'h30, 1'b0, "cfgp_addr_ack");
    wr(8'h01, 1'b0, "cfgp_ptr_ack");
    wr(8'h01, 1'b0, "cfgp_msb_ack");
    i2c_stop();
    expect_val("cfg_partial", 32'(config_o), 32'(m_cfg));
    i2c_start();
    wr(8'h30, 1'b0, "ro_addr_ack");
    wr(8'h05, 1'b0, "ro_ptr_ack");
    wr(8'hFF, 1'b0, "ro_msb_ack");
    wr(8'hFF, 1'b0, "ro_lsb_ack");
    wr(8'hFF, 1'b0, "ro_extra_ack");
    i2c_stop();
    expect_val("ro_regs", {t_upper_o, t_crit_o}, {m_up, m_crit});

    // Reset while the target drives a zero bit mid-byte
    i2c_start();
    wr(8'h30, 1'b0, "rr_addr_ack");
    wr(8'h06, 1'b0, "rr_ptr_ack");
    i2c_start();
    wr(8'h31, 1'b0, "rr_raddr_ack");
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    wait_clk(Q);
    expect_val("rr_driving", 32'(sda_bus), 32'h0);
    rst = 1'b0;
    #1;
    expect_val("rr_sda_released", 32'(sda_bus), 32'h1);
    model_reset();
    wait_clk(3);
    expect_val("rr_regs", {busy, res_o, t_upper_o, t_crit_o}, {1'b0, m_res, m_up, m_crit});
    rst = 1'b1;
    wait_clk(3);
    i2c_stop();

    // Resolution write then read; also proves the target recovered to IDLE
    i2c_start();
    wr(8'h30, 1'b0, "res_addr_ack");
    wr(8'h08, 1'b0, "res_ptr_ack");
    wr(8'h01, 1'b0, "res_data_ack");
    m_res = 2'b01;
    expect_val("res_o", 32'(res_o), 32'(m_res));
    i2c_stop();
    i2c_start();
    wr(8'h30, 1'b0, "resr_addr_ack");
    wr(8'h08, 1'b0, "resr_ptr_ack");
    i2c_start();
    wr(8'h31, 1'b0, "resr_raddr_ack");
    rd({6'b0, m_res}, 1'b0, "resr_b0");
    rd({6'b0, m_res}, 1'b1, "resr_b1");
    i2c_stop();

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
